// File: rtl/nes_pad_reader.sv
// Console-side NES controller reader: drives the pad's latch and shift clock,
// deserialises the eight active-low button bits and publishes an active-high byte.
module nes_pad_reader #(
  parameter int LATCH_CYCLES = 600,
  parameter int HALF_CYCLES  = 300,
  parameter int POLL_CYCLES  = 833333
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       auto_en,
  input  logic       pad_data,
  output logic       pad_latch,
  output logic       pad_clk,
  output logic [7:0] buttons,
  output logic       valid,
  output logic       busy
);

  localparam int PHASE_MAX = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
  localparam int CNT_W     = $clog2(PHASE_MAX) + 1;
  localparam int TMR_W     = $clog2(POLL_CYCLES) + 1;

  localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(LATCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(HALF_CYCLES - 1);
  localparam logic [TMR_W-1:0] POLL_LAST  = TMR_W'(POLL_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_GAP,
    S_CLK_HI,
    S_CLK_LO,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic [7:0]         buttons_q, buttons_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [1:0]         sync_q;
  logic               pad_latch_q, pad_clk_q, valid_q, busy_q;
  logic               pressed;
  logic               trigger;

  // Pad data is asynchronous to clk; only the second flop is ever sampled.
  assign pressed = ~sync_q[1];
  assign trigger = start || (auto_en && (timer_q == POLL_LAST));

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    bit_d     = bit_q;
    shift_d   = shift_q;
    buttons_d = buttons_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (trigger) begin
          state_d = S_LATCH;
          shift_d = '0;
        end
      end

      S_LATCH: begin
        if (cnt_q == LATCH_LAST) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end
      end

      S_GAP: begin
        if (cnt_q == HALF_LAST) begin
          state_d    = S_CLK_HI;
          cnt_d      = '0;
          shift_d[0] = pressed;
          bit_d      = 3'd1;
        end
      end

      S_CLK_HI: begin
        if (cnt_q == HALF_LAST) begin
          state_d = S_CLK_LO;
          cnt_d   = '0;
        end
      end

      S_CLK_LO: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d          = '0;
          shift_d[bit_q] = pressed;
          if (bit_q == 3'd7) begin
            state_d   = S_DONE;
            buttons_d = shift_d;
          end else begin
            state_d = S_CLK_HI;
            bit_d   = bit_q + 3'd1;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // The timer reads 0 during DONE, then counts up while auto polling is enabled.
  always_comb begin
    timer_d = timer_q + 1'b1;
    if (!auto_en || (state_d == S_DONE) || (timer_q == POLL_LAST)) begin
      timer_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      buttons_q   <= '0;
      timer_q     <= '0;
      sync_q      <= 2'b11;
      pad_latch_q <= 1'b0;
      pad_clk_q   <= 1'b0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      buttons_q   <= buttons_d;
      timer_q     <= timer_d;
      sync_q      <= {sync_q[0], pad_data};
      pad_latch_q <= (state_d == S_LATCH);
      pad_clk_q   <= (state_d == S_CLK_HI);
      valid_q     <= (state_d == S_DONE);
      busy_q      <= (state_d != S_IDLE);
    end
  end

  assign pad_latch = pad_latch_q;
  assign pad_clk   = pad_clk_q;
  assign buttons   = buttons_q;
  assign valid     = valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_nes_pad_reader.sv
// Self-checking bench for nes_pad_reader: a 4021-style pad model feeds the reader and
// every poll cycle is compared against waveforms derived from the phase lengths.
module tb_nes_pad_reader;

  localparam int L       = 4;
  localparam int H       = 3;
  localparam int P       = 100;
  localparam int DONE_AT = L + 15 * H + 1;     // cycle of the valid strobe
  localparam int AUTO_DD = (P - 1) + DONE_AT;  // DONE-to-DONE spacing under auto polling

  logic       clk = 1'b0;
  logic       rst_n, start, auto_en, pad_data;
  logic       pad_latch, pad_clk, valid, busy;
  logic [7:0] buttons;

  int checks   = 0;
  int failures = 0;

  nes_pad_reader #(
    .LATCH_CYCLES(L),
    .HALF_CYCLES (H),
    .POLL_CYCLES (P)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .auto_en  (auto_en),
    .pad_data (pad_data),
    .pad_latch(pad_latch),
    .pad_clk  (pad_clk),
    .buttons  (buttons),
    .valid    (valid),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Pad model: live active-low buttons are parallel-loaded on latch, shifted on pad_clk.
  logic [7:0] pad_n  = 8'hFF;
  logic [7:0] pad_sr = 8'hFF;
  logic       glitch = 1'b0;
  int         clk_pulses = 0;

  always @(posedge pad_latch or posedge pad_clk) begin
    if (pad_latch) pad_sr <= pad_n;
    else           pad_sr <= {1'b1, pad_sr[7:1]};
  end

  always @(posedge pad_clk) clk_pulses <= clk_pulses + 1;

  assign pad_data = pad_sr[0] | glitch;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check({tag, "_busy"}, 32'(busy), 32'(1'b0));
      check({tag, "_valid"}, 32'(valid), 32'(1'b0));
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Runs one poll from a start pulse and checks every cycle up to the first idle cycle.
  task automatic run_poll(input string tag, input logic [7:0] exp_b, input logic [7:0] prev_b,
                          input int restart_at, input logic [7:0] new_pad_n, input int glitch_at);
    int  pulses0;
    logic exp_clk;
    @(negedge clk);
    start   = 1'b1;
    pulses0 = clk_pulses;
    for (int c = 1; c <= DONE_AT + 1; c++) begin
      @(negedge clk);
      exp_clk = (c > L + H) && (c <= L + 15 * H) && ((((c - L - H - 1) / H) % 2) == 0);
      check({tag, "_latch"}, 32'(pad_latch), 32'(c <= L));
      check({tag, "_pclk"}, 32'(pad_clk), 32'(exp_clk));
      check({tag, "_valid"}, 32'(valid), 32'(c == DONE_AT));
      check({tag, "_busy"}, 32'(busy), 32'(c <= DONE_AT));
      check({tag, "_buttons"}, 32'(buttons), 32'((c >= DONE_AT) ? exp_b : prev_b));
      start  = (c == restart_at);
      glitch = (c == glitch_at);
      if (c == restart_at) pad_n = new_pad_n;
    end
    start  = 1'b0;
    glitch = 1'b0;
    check({tag, "_pulses"}, 32'(clk_pulses - pulses0), 32'd7);
  endtask

  initial begin
    logic [7:0] prev;
    logic [7:0] exp_b;
    bit         found;

    rst_n   = 1'b0;
    start   = 1'b0;
    auto_en = 1'b0;

    // 1: reset state, both during and after reset
    #23;
    check("rst_buttons", 32'(buttons), 32'h00);
    check("rst_latch", 32'(pad_latch), 32'(1'b0));
    check("rst_pclk", 32'(pad_clk), 32'(1'b0));
    check("rst_busy", 32'(busy), 32'(1'b0));
    check("rst_valid", 32'(valid), 32'(1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    check_idle("post_rst", 3);
    check("post_rst_buttons", 32'(buttons), 32'h00);

    // 2: A and Right pressed
    pad_n = 8'h7E;
    run_poll("ar", 8'h81, 8'h00, 0, 8'h00, 0);
    check_idle("ar_idle", 5);

    // 3: start while busy is dropped; mid-poll button changes are invisible
    reset_dut();
    pad_n = 8'h7E;
    run_poll("busy_start", 8'h81, 8'h00, 20, 8'h00, 0);
    check_idle("busy_start_idle", 12);

    // random button patterns with random idle gaps
    prev = 8'h81;
    for (int r = 0; r < 6; r++) begin
      pad_n = 8'($urandom);
      if (r == 5) pad_n[0] = 1'b0;
      exp_b = ~pad_n;
      for (int d = 0; d < int'($urandom_range(0, 5)); d++) @(negedge clk);
      run_poll("rand", exp_b, prev, 0, 8'h00, 0);
      prev = exp_b;
    end

    // 5: reset mid-poll aborts immediately
    pad_n = 8'h00;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      start = 1'b0;
      check("abort_no_valid", 32'(valid), 32'(1'b0));
      check("abort_hold", 32'(buttons), 32'(prev));
    end
    rst_n = 1'b0;
    #1;
    check("abort_latch", 32'(pad_latch), 32'(1'b0));
    check("abort_pclk", 32'(pad_clk), 32'(1'b0));
    check("abort_busy", 32'(busy), 32'(1'b0));
    check("abort_buttons", 32'(buttons), 32'h00);
    check("abort_valid", 32'(valid), 32'(1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    check_idle("abort_idle", 60);
    pad_n = 8'hA5;
    run_poll("after_abort", 8'h5A, 8'h00, 0, 8'h00, 0);

    // 6: all pressed with a one-cycle glitch high in the middle of a CLK_HI phase
    pad_n = 8'h00;
    run_poll("glitch", 8'hFF, 8'h5A, 0, 8'h00, L + 3 * H + 2);

    // 4: auto polling with nothing pressed
    pad_n   = 8'hFF;
    auto_en = 1'b1;
    found   = 1'b0;
    for (int i = 0; i < 3 * P && !found; i++) begin
      @(negedge clk);
      if (valid === 1'b1) found = 1'b1;
    end
    check("auto_first", 32'(found), 32'(1'b1));
    if (found) begin
      check("auto_first_buttons", 32'(buttons), 32'h00);
      for (int r = 0; r < 2; r++) begin
        for (int j = 1; j <= AUTO_DD; j++) begin
          @(negedge clk);
          check("auto_valid", 32'(valid), 32'(j == AUTO_DD));
          check("auto_busy", 32'(busy), 32'(j >= P));
          if (j == AUTO_DD) check("auto_buttons", 32'(buttons), 32'h00);
          start = (r == 1) && (j == P - 1);
        end
      end
    end
    start   = 1'b0;
    auto_en = 1'b0;
    check_idle("auto_single", 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
